// File: rtl/stopwatch_pkg.sv
// Shared widths, segment patterns and run-state type for the BCD stopwatch.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_n_bcd_digit_cell.sv
// One BCD digit register. co flags the digit sitting at its roll-over limit
// (9 counting up, 0 counting down) so the next digit may step with it.
module bcd_digit_cell
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               down,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               co
);

  assign co = down ? (digit == '0) : (digit == BCD_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      if (down)
        digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
      else
        digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_n.sv
// NUM_DIGITS-wide BCD stopwatch with prescaler, start/stop toggle, up/down and wrap flag.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_HOLD_EN is defined.
//
// state   | meaning
// ST_STOP | counter and prescaler frozen
// ST_RUN  | prescaler advancing, digits step on each tick
module stopwatch_bcd_n
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          down,
  input  logic                          lap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
  output logic [SEG_W*NUM_DIGITS-1:0]   seg_out,
  output logic                          running,
  output logic                          wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  run_state_t state, state_nxt;
  logic          ss_q;
  logic          ss_edge;
  logic [PW-1:0] presc;
  logic          tick;

  logic [DIGIT_W*NUM_DIGITS-1:0] live;
  logic [DIGIT_W*NUM_DIGITS-1:0] disp;
  logic [NUM_DIGITS:0]           en_chain;
  logic [NUM_DIGITS-1:0]         at_lim;

  assign ss_edge = start_stop & ~ss_q;
  assign running = (state == ST_RUN);
  assign tick    = running & (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_STOP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = ST_STOP;
    else if (ss_edge)
      state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q  <= 1'b0;
      presc <= '0;
      wrap  <= 1'b0;
    end else begin
      ss_q <= start_stop;
      if (clear) begin
        presc <= '0;
        wrap  <= 1'b0;
      end else begin
        if (tick)         presc <= '0;
        else if (running) presc <= presc + 1'b1;
        // every digit at its limit on a tick means the whole range rolls over
        wrap <= en_chain[NUM_DIGITS];
      end
    end
  end

  assign en_chain[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (en_chain[i]),
      .down  (down),
      .clr   (clear),
      .digit (live[DIGIT_W*i +: DIGIT_W]),
      .co    (at_lim[i])
    );
    assign en_chain[i+1] = en_chain[i] & at_lim[i];
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                          lap_q;
  logic                          hold;
  logic [DIGIT_W*NUM_DIGITS-1:0] snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q <= 1'b0;
      hold  <= 1'b0;
      snap  <= '0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        hold <= 1'b0;
      end else if (lap & ~lap_q) begin
        hold <= ~hold;
        if (!hold) snap <= live;
      end
    end
  end

  assign disp = hold ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = live;
`endif

  assign bcd_out = disp;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
    assign seg_out[SEG_W*i +: SEG_W] = seg_encode(disp[DIGIT_W*i +: DIGIT_W]);
  end

endmodule

// File: doc/stopwatch_bcd_n.md
Name: stopwatch_bcd_n

Overview:
Parametrised successor to the two-digit stopwatch. It is an NUM_DIGITS-wide cascaded BCD counter with a clock prescaler, edge-detected start/stop toggle, synchronous clear, and up/down mode. It drives one 7-segment pattern per digit and flags wrap-around. It sits between the board's button conditioning and the display mux.

Parameters:
NUM_DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
TICK_DIV, 1, clk cycles per count step while running (>=1).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start_stop  in  1  level input; each rising edge toggles run state
clear  in  1  synchronous clear, active-high
down  in  1  0 = count up, 1 = count down; sampled every tick
lap  in  1  lap-hold request (used only with LAP_HOLD_EN)
bcd_out  out  4*NUM_DIGITS  displayed digits, digit i at [4i+3:4i]
seg_out  out  7*NUM_DIGITS  segments per digit, {g,f,e,d,c,b,a}, active-high
running  out  1  1 while counting
wrap  out  1  one-cycle pulse on full-range wrap

Behaviour:
- Reset (reset=0, async): all digits 0, prescaler 0, running 0, wrap 0, start_stop/lap edge registers 0, hold 0.
- Edge detect: ss_edge = start_stop & ~ss_q, where ss_q is start_stop registered each cycle. On the edge where ss_edge=1, running <= ~running. No debounce is performed; the input is pre-conditioned upstream.
- Prescaler: advances only while running, counting 0..TICK_DIV-1. tick = running & (presc==TICK_DIV-1); presc returns to 0 on tick. Pausing holds presc, so resume keeps the fractional interval. With TICK_DIV=1, tick = running.
- Count: digits update on the clock edge ending a tick cycle.
  - Up: digit i increments when tick and all lower digits == 9; 9 -> 0.
  - Down: digit i decrements when tick and all lower digits == 0; 0 -> 9.
- Wrap: all-9 -> all-0 (up) or all-0 -> all-9 (down). wrap is registered and high for exactly the one cycle in which the wrapped value is presented. Counting continues after a wrap; there is no auto-stop.
- Latency: start_stop sampled high at edge E0 -> running=1 after E0. With TICK_DIV=1, first count change at E1.
- clear=1: digits 0, presc 0, running 0, wrap 0, hold 0 on the next edge. Clear overrides a simultaneous ss_edge (no toggle), but ss_q still updates.
- down changing mid-run takes effect at the next tick. Digit values >9 are unreachable.
- seg_out is combinational from the displayed digits. Encoding: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, other=0000000.

Optional Feature:
Macro STOPWATCH_LAP_HOLD_EN.
- Defined: a rising edge of lap (registered edge detect) toggles hold. On hold entry, the current digits are captured into a snapshot register. While hold=1, bcd_out and seg_out show the snapshot, while the counter, running and wrap continue live. clear or reset sets hold=0.
- Undefined: lap is ignored, no snapshot register is built, and bcd_out always shows the live count.

Decomposition:
- Package stopwatch_pkg: DIGIT_W=4, SEG_W=7, segment pattern constants SEG_0..SEG_9 and SEG_OFF, BCD_MAX=4'd9.
- Sub-module bcd_digit_cell: one digit register with en, down, clr inputs and a carry/borrow-out (digit==9 up / digit==0 down). Instantiate NUM_DIGITS copies in a generate loop, chaining the carry.
- The segment encoder is a package function, not a module.

Test Plan:
1. NUM_DIGITS=2, TICK_DIV=4: release reset -> bcd_out=8'h00, seg_out={0111111,0111111}, running=0, wrap=0.
2. One-cycle start_stop pulse, then 40 clk cycles -> bcd_out=8'h10, running=1. A second pulse stops it; the value holds at 8'h10 for 20 more cycles.
3. TICK_DIV=1, up mode, start, 100 ticks -> bcd_out passes 8'h99 then 8'h00; wrap=1 for exactly the 00 cycle, otherwise 0.
4. TICK_DIV=1, down=1 from 8'h00, start, 1 tick -> bcd_out=8'h99 and wrap pulses. 10 more ticks -> 8'h89.
5. While running at 8'h37: clear and a start_stop rising edge in the same cycle -> bcd_out=8'h00, running=0. Separately, assert reset=0 mid-tick -> outputs clear immediately, without waiting for clk.
6. With STOPWATCH_LAP_HOLD_EN: lap edge at 8'h12 -> bcd_out stays 8'h12 while the live count reaches 8'h20. A second lap edge -> bcd_out=8'h20 immediately.
